// File: rtl/io_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : io_uart_pkg
//  Purpose  : Register offsets, STATUS bit positions and transmit FSM states
//             shared by the memory-mapped UART transmitter.
//  Revision : 1.0
// ============================================================================
package io_uart_pkg;

    localparam logic [1:0] REG_TXDATA   = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_DIVISOR  = 2'd2;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_FULL     = 1;
    localparam int STAT_EMPTY    = 2;
    localparam int STAT_OVERFLOW = 3;
    localparam int STAT_CNT_LSB  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : Synchronous FIFO with a combinational head output; a push while
//             full is accepted when a pop happens in the same cycle.
//  Revision : 1.0
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               pop_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        count    = count_q;
        pop_data = mem_q[rd_ptr_q];
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        // Depth is a power of two, so the pointers wrap naturally.
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/io_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : io_uart_tx
//  Purpose  : Memory-mapped 8N1 UART transmitter with TX FIFO, programmable
//             baud divisor and sticky overflow status.
//  Revision : 1.0
// ============================================================================
module io_uart_tx
    import io_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_RESET  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] io_address,
    input  logic [31:0] io_write_value,
    input  logic        io_write_en,
    input  logic        io_read_en,
    output logic [31:0] io_read_value,
    output logic        uart_tx
);

    localparam int CW = $clog2(FIFO_DEPTH+1);

    logic            wr_txdata, wr_status, wr_divisor;
    logic [7:0]      fifo_head;
    logic            fifo_full, fifo_empty, fifo_pop;
    logic [CW-1:0]   fifo_count;
    logic            busy;

    tx_state_e       state_q, state_d;
    logic [15:0]     baud_q, baud_d;
    logic [15:0]     frame_div_q, frame_div_d;
    logic [15:0]     div_q, div_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            overflow_q, overflow_d;
    logic            unused_bits;

    assign unused_bits = ^{io_address[31:4], io_address[1:0], io_write_value[31:16]};

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_txdata),
        .push_data (io_write_value[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        wr_txdata  = io_write_en && (io_address[3:2] == REG_TXDATA);
        wr_status  = io_write_en && (io_address[3:2] == REG_STATUS);
        wr_divisor = io_write_en && (io_address[3:2] == REG_DIVISOR);

        div_d = div_q;
        if (wr_divisor) begin
            div_d = (io_write_value[15:0] == 16'd0) ? 16'd1 : io_write_value[15:0];
        end

        // A push into a full FIFO still succeeds if the FSM frees a slot now.
        overflow_d = overflow_q;
        if (wr_status) begin
            overflow_d = 1'b0;
        end else if (wr_txdata && fifo_full && !fifo_pop) begin
            overflow_d = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        frame_div_d = frame_div_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        fifo_pop    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    shift_d     = fifo_head;
                    frame_div_d = div_q;
                    baud_d      = div_q - 16'd1;
                    tx_d        = 1'b0;
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                if (baud_q == 16'd0) begin
                    baud_d    = frame_div_q - 16'd1;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                    state_d   = ST_DATA;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_q == 16'd0) begin
                    baud_d = frame_div_q - 16'd1;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (baud_q == 16'd0) begin
                    // Chain straight into the next start bit when data waits.
                    if (!fifo_empty) begin
                        fifo_pop    = 1'b1;
                        shift_d     = fifo_head;
                        frame_div_d = div_q;
                        baud_d      = div_q - 16'd1;
                        tx_d        = 1'b0;
                        state_d     = ST_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            baud_q      <= 16'd0;
            frame_div_q <= 16'(DIV_RESET);
            div_q       <= 16'(DIV_RESET);
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'd0;
            tx_q        <= 1'b1;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            frame_div_q <= frame_div_d;
            div_q       <= div_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        busy          = (state_q != ST_IDLE);
        uart_tx       = tx_q;
        io_read_value = 32'd0;
        if (io_read_en) begin
            case (io_address[3:2])
                REG_STATUS: begin
                    io_read_value[STAT_BUSY]           = busy;
                    io_read_value[STAT_FULL]           = fifo_full;
                    io_read_value[STAT_EMPTY]          = fifo_empty;
                    io_read_value[STAT_OVERFLOW]       = overflow_q;
                    io_read_value[STAT_CNT_LSB +: 4]   = 4'(fifo_count);
                end
                REG_DIVISOR: io_read_value[15:0] = div_q;
                default:     io_read_value = 32'd0;
            endcase
        end
    end

endmodule
`default_nettype wire
